// File: rtl/imem_loader_if.sv
// Boot loader bus: byte stream in, instruction memory write port
// and load status out.
interface imem_loader_if #(
   parameter int CNT_W = 6
);
   logic             start;
   logic [7:0]       in_byte;
   logic             in_valid;
   logic             in_ready;
   logic             mem_we;
   logic [31:0]      mem_waddr;
   logic [31:0]      mem_wdata;
   logic             busy;
   logic             done;
   logic             error;
   logic [CNT_W-1:0] words_loaded;

   modport master (
      output start, in_byte, in_valid,
      input  in_ready, mem_we, mem_waddr, mem_wdata,
      input  busy, done, error, words_loaded
   );

   modport slave (
      input  start, in_byte, in_valid,
      output in_ready, mem_we, mem_waddr, mem_wdata,
      output busy, done, error, words_loaded
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: framed byte stream to instruction memory,
// little-endian word assembly and XOR checksum.
module imem_loader #(
   parameter int DEPTH = 32,
   parameter int CNT_W = 6
) (
   input logic         clock,
   input logic         reset,
   imem_loader_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR
   } state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   state_t           state;
   logic [1:0]       k;
   logic [7:0]       csum;
   logic [CNT_W-1:0] widx;
   logic [CNT_W-1:0] len;
   logic             acc;

   assign acc = bus.in_valid && bus.in_ready;
   assign bus.words_loaded = widx;

   // Frame sequencer; every output is registered with its next state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         k             <= '0;
         csum          <= '0;
         widx          <= '0;
         len           <= '0;
         bus.in_ready  <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_waddr <= '0;
         bus.mem_wdata <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.error     <= 1'b0;
      end else begin
         bus.mem_we <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (bus.start) begin
                  state        <= LEN;
                  bus.in_ready <= 1'b1;
                  bus.busy     <= 1'b1;
                  bus.done     <= 1'b0;
                  bus.error    <= 1'b0;
                  widx         <= '0;
                  k            <= '0;
                  csum         <= '0;
               end
            end
            LEN: begin
               if (acc) begin
                  if (bus.in_byte != 8'd0 &&
                      32'(bus.in_byte) <= DEPTH_W) begin
                     len   <= CNT_W'(bus.in_byte);
                     state <= DATA;
                  end else begin
                     state        <= ERR;
                     bus.in_ready <= 1'b0;
                     bus.busy     <= 1'b0;
                     bus.error    <= 1'b1;
                  end
               end
            end
            DATA: begin
               if (acc) begin
                  bus.mem_wdata[{k, 3'b000} +: 8] <= bus.in_byte;
                  csum <= csum ^ bus.in_byte;
                  k    <= k + 2'd1;
                  if (k == 2'd3) begin
                     state         <= WRITE;
                     bus.in_ready  <= 1'b0;
                     bus.mem_we    <= 1'b1;
                     bus.mem_waddr <= 32'(widx);
                  end
               end
            end
            WRITE: begin
               widx         <= widx + ONE;
               k            <= '0;
               bus.in_ready <= 1'b1;
               state        <= (widx + ONE == len) ? CSUM : DATA;
            end
            CSUM: begin
               if (acc) begin
                  bus.in_ready <= 1'b0;
                  bus.busy     <= 1'b0;
                  if (bus.in_byte == csum) begin
                     state    <= DONE;
                     bus.done <= 1'b1;
                  end else begin
                     state     <= ERR;
                     bus.error <= 1'b1;
                  end
               end
            end
            default: begin
               state        <= IDLE;
               bus.in_ready <= 1'b0;
               bus.busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
